// File: rtl/axi4_write_responder_if.sv
// AXI4 write-channel bundle (AW, W, B) between a write master
// and the write responder.
interface axi4_write_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   AWID;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_WIDTH-1:0] WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;

    logic [ID_WIDTH-1:0]   BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/axi4_write_responder.sv
// Single-outstanding AXI4 write slave: streams accepted beats onto a
// synchronous memory write port, then returns one B response.
module axi4_write_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    axi4_write_responder_if.slave axi,
    output logic                  MEM_WEN,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    output logic [STRB_WIDTH-1:0] MEM_WSTRB
);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_WIDTH));

    typedef enum logic [1:0] {
        RST  = 2'd0,
        IDLE = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [7:0]            cnt_q;
    logic                  err_q;

    logic aw_hs, w_hs, b_hs;
    logic last_beat;
    logic len_ok, aw_err, wlast_err;

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] addr_nx;

    assign axi.AWREADY = (state_q == IDLE);
    assign axi.WREADY  = (state_q == DATA);
    assign axi.BVALID  = (state_q == RESP);
    assign axi.BID     = id_q;
    assign axi.BRESP   = {err_q, 1'b0};

    assign aw_hs = axi.AWVALID & axi.AWREADY;
    assign w_hs  = axi.WVALID & axi.WREADY;
    assign b_hs  = axi.BVALID & axi.BREADY;

    assign last_beat = (cnt_q == len_q);

    assign len_ok = (axi.AWLEN == 8'd1) | (axi.AWLEN == 8'd3)
                  | (axi.AWLEN == 8'd7) | (axi.AWLEN == 8'd15);

    assign aw_err = (axi.AWSIZE > MAX_SIZE)
                  | (axi.AWBURST == 2'b11)
                  | ((axi.AWBURST == 2'b10) & ~len_ok);

    // WLAST is only checked; the beat counter alone ends the burst.
    assign wlast_err = axi.WLAST ^ last_beat;

    assign MEM_WEN   = w_hs & ~err_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = axi.WDATA;
    assign MEM_WSTRB = axi.WSTRB;

    always_comb begin
        step      = ADDR_WIDTH'(1) << size_q;
        incr      = addr_q + step;
        wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q)
                  - ADDR_WIDTH'(1);
        addr_nx   = incr;
        unique case (burst_q)
            2'b00:   addr_nx = addr_q;
            2'b10:   addr_nx = (addr_q & ~wrap_mask) | (incr & wrap_mask);
            default: addr_nx = incr;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RST:  state_d = IDLE;
            IDLE: if (aw_hs) state_d = DATA;
            DATA: if (w_hs && last_beat) state_d = RESP;
            RESP: if (b_hs) state_d = IDLE;
            default: state_d = RST;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else if (aw_hs) begin
            id_q    <= axi.AWID;
            addr_q  <= axi.AWADDR;
            len_q   <= axi.AWLEN;
            size_q  <= axi.AWSIZE;
            burst_q <= axi.AWBURST;
            cnt_q   <= '0;
            err_q   <= aw_err;
        end else if (w_hs) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= addr_nx;
            if (wlast_err) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi4_write_responder.sv
// Randomized self-checking bench for axi4_write_responder against
// a burst-level reference model.
module tb_axi4_write_responder;
    logic        CLK = 1'b0;
    logic        RESETn;
    logic        MEM_WEN;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [3:0]  MEM_WSTRB;

    int n_chk = 0;
    int n_fail = 0;

    axi4_write_responder_if #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)
    ) axi ();

    axi4_write_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)
    ) dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .axi      (axi),
        .MEM_WEN  (MEM_WEN),
        .MEM_ADDR (MEM_ADDR),
        .MEM_WDATA(MEM_WDATA),
        .MEM_WSTRB(MEM_WSTRB)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte address of beat i, straight from the burst-type rules.
    function automatic logic [31:0] beat_addr(input logic [31:0] a,
                                              input int len,
                                              input int size,
                                              input int bt,
                                              input int i);
        longint nb, tot, base, av;
        nb = longint'(1) << size;
        tot = longint'(len + 1) * nb;
        av = longint'(a);
        case (bt)
            0: return a;
            2: begin
                base = av - (av % tot);
                return 32'(base + ((av - base) + i * nb) % tot);
            end
            default: return 32'(av + i * nb);
        endcase
    endfunction

    task automatic idle_outs(input string tag);
        chk({tag, "_awready"}, axi.AWREADY, 0);
        chk({tag, "_wready"}, axi.WREADY, 0);
        chk({tag, "_bvalid"}, axi.BVALID, 0);
        chk({tag, "_wen"}, MEM_WEN, 0);
        chk({tag, "_bid"}, axi.BID, 0);
        chk({tag, "_bresp"}, axi.BRESP, 0);
    endtask

    task automatic run_burst(input logic [3:0] id,
                             input logic [31:0] addr,
                             input int len, input int size,
                             input int bt, input int gapm,
                             input int mis, input int bp,
                             input logic [31:0] d0);
        bit err, wv, gap;
        int i;
        logic [3:0] stb;
        err = (size > 2) || (bt == 3)
           || (bt == 2 && !(len inside {1, 3, 7, 15}));
        @(negedge CLK);
        axi.AWVALID = 1'b1;
        axi.AWID    = id;
        axi.AWADDR  = addr;
        axi.AWLEN   = 8'(len);
        axi.AWSIZE  = 3'(size);
        axi.AWBURST = 2'(bt);
        #1;
        chk("awready", axi.AWREADY, 1);
        chk("wready_idle", axi.WREADY, 0);
        @(negedge CLK);
        axi.AWVALID = 1'b0;
        axi.AWADDR  = $urandom;
        axi.AWID    = 4'($urandom);
        i = 0;
        gap = 1'b1;
        while (i <= len) begin
            case (gapm)
                0: wv = 1'b1;
                1: wv = gap;
                default: wv = gap ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            gap = !wv;
            stb = 4'($urandom);
            axi.WVALID = wv;
            axi.WDATA  = d0 + 32'(i);
            axi.WSTRB  = stb;
            axi.WLAST  = (i == len) != (i == mis);
            #1;
            chk("wready", axi.WREADY, 1);
            chk("bvalid_data", axi.BVALID, 0);
            chk("awready_data", axi.AWREADY, 0);
            chk("mem_wen", MEM_WEN, wv && !err);
            if (wv && !err) begin
                chk("mem_addr", MEM_ADDR,
                    beat_addr(addr, len, size, bt, i));
                chk("mem_wdata", MEM_WDATA, d0 + 32'(i));
                chk("mem_wstrb", MEM_WSTRB, stb);
            end
            if (wv) begin
                if (i == mis) err = 1'b1;
                i++;
            end
            @(negedge CLK);
        end
        axi.WVALID = 1'b0;
        axi.WLAST  = 1'b0;
        axi.BREADY = 1'b0;
        for (int k = 0; k < bp; k++) begin
            #1;
            chk("bp_bvalid", axi.BVALID, 1);
            chk("bp_bid", axi.BID, id);
            chk("bp_bresp", axi.BRESP, err ? 2'b10 : 2'b00);
            chk("bp_awready", axi.AWREADY, 0);
            @(negedge CLK);
        end
        axi.BREADY = 1'b1;
        #1;
        chk("bvalid", axi.BVALID, 1);
        chk("wready_resp", axi.WREADY, 0);
        chk("bid", axi.BID, id);
        chk("bresp", axi.BRESP, err ? 2'b10 : 2'b00);
        @(negedge CLK);
        axi.BREADY = 1'b0;
        #1;
        chk("awready_after_b", axi.AWREADY, 1);
        chk("bvalid_after_b", axi.BVALID, 0);
    endtask

    task automatic reset_mid_burst();
        @(negedge CLK);
        axi.AWVALID = 1'b1;
        axi.AWID    = 4'hC;
        axi.AWADDR  = 32'h200;
        axi.AWLEN   = 8'd7;
        axi.AWSIZE  = 3'd2;
        axi.AWBURST = 2'b01;
        @(negedge CLK);
        axi.AWVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            axi.WVALID = 1'b1;
            axi.WDATA  = $urandom;
            axi.WLAST  = 1'b0;
            #1;
            chk("rst_pre_wen", MEM_WEN, 1);
            @(negedge CLK);
        end
        #1;
        RESETn = 1'b0;
        #1;
        idle_outs("rst_mid");
        @(negedge CLK);
        axi.WVALID = 1'b0;
        @(negedge CLK);
        RESETn = 1'b1;
        #1;
        idle_outs("rst_rel");
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            #1;
            chk("rst_awready", axi.AWREADY, 1);
            chk("rst_no_bvalid", axi.BVALID, 0);
        end
    endtask

    initial begin
        int bt, len, mis;
        RESETn = 1'b0;
        axi.AWVALID = 1'b0;
        axi.AWID = '0;
        axi.AWADDR = '0;
        axi.AWLEN = '0;
        axi.AWSIZE = '0;
        axi.AWBURST = '0;
        axi.WVALID = 1'b0;
        axi.WDATA = '0;
        axi.WSTRB = '0;
        axi.WLAST = 1'b0;
        axi.BREADY = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        idle_outs("reset");
        @(negedge CLK);
        RESETn = 1'b1;
        #1;
        idle_outs("first_cycle");
        @(negedge CLK);
        #1;
        chk("awready_boot", axi.AWREADY, 1);

        run_burst(4'h5, 32'h100, 3, 2, 1, 0, -1, 0, 32'hA0);
        run_burst(4'h6, 32'h108, 3, 2, 2, 0, -1, 0, 32'hB0);
        run_burst(4'h7, 32'h020, 2, 2, 0, 1, -1, 0, 32'hC0);
        run_burst(4'h8, 32'h040, 1, 3, 1, 0, -1, 0, 32'hD0);
        run_burst(4'h9, 32'h050, 1, 2, 1, 0, 0, 0, 32'hE0);
        run_burst(4'hA, 32'h060, 2, 2, 1, 0, -1, 5, 32'hF0);
        run_burst(4'hB, 32'h070, 5, 2, 2, 0, -1, 1, 32'h10);
        run_burst(4'h3, 32'hFFFF_FFF8, 3, 2, 1, 0, -1, 0, 32'h20);
        reset_mid_burst();

        for (int n = 0; n < 60; n++) begin
            bt = $urandom_range(0, 3);
            if (bt == 2 && $urandom_range(0, 3) != 0)
                len = (2 << $urandom_range(0, 3)) - 1;
            else
                len = $urandom_range(0, 15);
            mis = ($urandom_range(0, 3) == 0)
                ? $urandom_range(0, len) : -1;
            run_burst(4'($urandom), $urandom, len,
                      $urandom_range(0, 3), bt,
                      $urandom_range(0, 2), mis,
                      $urandom_range(0, 3), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi4_write_responder.md
# axi4_write_responder

AXI4 write-side responder (slave) for the AXI4Bus fabric. It accepts one write burst at a time on the AW and W channels and drives each accepted data beat onto a simple synchronous memory write port. It then returns a single B response. It is the receiving end of the valid/ready write traffic that masters and FIFOs in the fabric produce.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; one of 8/16/32/64/128; STRB_WIDTH = DATA_WIDTH/8
- ID_WIDTH, 4, AXI ID width

Ports:
- CLK  in  1  clock, rising edge
- RESETn  in  1  reset, asynchronous, active-low
- AWID  in  ID_WIDTH  burst ID
- AWADDR  in  ADDR_WIDTH  start byte address
- AWLEN  in  8  beats minus one
- AWSIZE  in  3  log2 bytes per beat
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- AWVALID / AWREADY  in / out  1  AW handshake
- WDATA  in  DATA_WIDTH  write data
- WSTRB  in  STRB_WIDTH  byte strobes
- WLAST  in  1  last beat marker
- WVALID / WREADY  in / out  1  W handshake
- BID  out  ID_WIDTH  response ID
- BRESP  out  2  00 OKAY, 10 SLVERR
- BVALID / BREADY  out / in  1  B handshake
- MEM_WEN  out  1  memory write enable
- MEM_ADDR  out  ADDR_WIDTH  byte address of the current beat
- MEM_WDATA  out  DATA_WIDTH  equals WDATA
- MEM_WSTRB  out  STRB_WIDTH  equals WSTRB

## Operation
- State register with four states: RST, IDLE, DATA, RESP. Reset state is RST. RST moves to IDLE on the first CLK edge after RESETn is released.
- AWREADY = (state==IDLE). WREADY = (state==DATA). BVALID = (state==RESP). All three are decoded from the state register only.
- IDLE: on AWVALID&AWREADY, latch ID, ADDR, LEN, SIZE and BURST. Clear the beat counter and the error flag, then go to DATA.
- Error flag is set at AW acceptance if either condition holds:
  - AWSIZE > log2(STRB_WIDTH)
  - AWBURST==11
- DATA: each WVALID&WREADY is one beat.
  - MEM_WEN = WVALID & WREADY & ~error. It is combinational, in the same cycle as the handshake.
  - MEM_ADDR = current beat address register.
- Address update after each beat:
  - FIXED: unchanged.
  - INCR: addr + (1<<SIZE), modulo 2^ADDR_WIDTH.
  - WRAP: increment, but wrap within the aligned block of size (LEN+1)<<SIZE.
  - WRAP with LEN not in {1,3,7,15} sets the error flag at AW acceptance.
- Beat counter (8 bits) counts accepted beats. The burst ends on the beat where counter==LEN; that beat goes to RESP. Termination is counter-based only.
- WLAST mismatch sets the error flag but does not change termination. Mismatch means either:
  - WLAST=1 on a beat with counter!=LEN, or
  - WLAST=0 on the beat with counter==LEN.
- Writes already issued before an error is detected are not undone. Once the flag is set, MEM_WEN stays 0 for the remaining beats.
- RESP: BID = latched ID. BRESP = error ? 10 : 00. On BVALID&BREADY go to IDLE.
- Outstanding bursts: exactly one. No AW is accepted while in DATA or RESP.

## Timing
- Reset values, while RESETn is low and for the first cycle after release:
  - AWREADY=0, WREADY=0, BVALID=0, MEM_WEN=0
  - BID=0, BRESP=00; all internal registers 0
- AW handshake at edge t. WREADY is 1 from cycle t+1.
- With WVALID held high, the last beat completes at edge t+1+LEN. BVALID is 1 from cycle t+2+LEN.
- B handshake at edge r. AWREADY is 1 in cycle r+1. Minimum burst period is LEN+3 cycles.
- BID and BRESP are stable while BVALID=1 and BREADY=0.
- MEM_* outputs have zero-cycle latency relative to the W handshake.
- RESETn asserted mid-burst: all outputs return to reset values immediately. The burst is abandoned and no B response is produced.
- WVALID gaps in DATA: counter and address hold; MEM_WEN=0.

## Test plan
- INCR burst: AWADDR=0x100, LEN=3, SIZE=2, data 0xA0..0xA3 with WLAST on beat 3.
  - MEM writes at 0x100, 0x104, 0x108, 0x10C.
  - BRESP=00, BID echoed; BVALID in cycle t+5.
- WRAP burst: AWADDR=0x108, LEN=3, SIZE=2.
  - MEM_ADDR sequence 0x108, 0x10C, 0x100, 0x104; BRESP=00.
- FIXED burst: AWADDR=0x20, LEN=2, with WVALID toggling 1,0,1,0,1.
  - Three writes, all at 0x20; no MEM_WEN in the gap cycles.
- Errors:
  - AWSIZE=3 with DATA_WIDTH=32, LEN=1: zero MEM_WEN; BRESP=10 after 2 beats.
  - WLAST early on beat 0 of LEN=1: one write, then BRESP=10 after beat 1.
- Back-pressure: hold BREADY=0 for 5 cycles.
  - BVALID, BID and BRESP stable; AWREADY=0 throughout.
  - AWREADY=1 the cycle after the B handshake.
- Reset on beat 2 of a LEN=7 burst: outputs return to reset values immediately, no BVALID follows, and AWREADY=1 on the 2nd edge after release.
